// File: rtl/ddr_vector_responder_pkg.sv
// Shared types for the load/store unit's vector path and its memory-side responder.
package ddr_vector_responder_pkg;

    localparam int DdrAddressWidth   = 16;
    localparam int DdrDataWidth      = 8;
    localparam int D                 = 4;
    localparam int ResponderMemDepth = 256;

    typedef logic [DdrAddressWidth-1:0] ddr_address_t;
    typedef logic [DdrDataWidth-1:0]    ddr_data_t;
    typedef logic [$clog2(D)-1:0]       DI_t;

    // Only LDV and SV are defined; encodings 2 and 3 are rejected by the responder.
    typedef enum logic [1:0] {
        LDV = 2'd0,
        SV  = 2'd1
    } load_store_operation_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_WAIT   = 2'd1,
        ST_RD_STREAM = 2'd2,
        ST_WR_STREAM = 2'd3
    } responder_state_t;

endpackage

// File: rtl/ddr_mem_array.sv
// Single-port word RAM: one write per cycle or one registered read per cycle.
// The storage has no reset; only the read-data register is cleared so the
// responder's data output starts at zero.
module ddr_mem_array #(
    parameter int Depth = 256,
    parameter int Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_r [Depth];
    logic [Width-1:0] rdata_r;

    // Storage write port, deliberately without reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[addr_i] <= wdata_i;
        end
    end

    // Read register: updates only on a read so the value holds during stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_r <= '0;
        end else if (re_i) begin
            rdata_r <= mem_r[addr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/ddr_vector_responder.sv
// Memory-side responder for vector loads (LDV) and stores (SV) of D elements.
// The first read word is fetched at request acceptance; each read handshake
// fetches the following word so beats can stream at one per cycle.
module ddr_vector_responder
    import ddr_vector_responder_pkg::*;
#(
    parameter int MemDepth    = ResponderMemDepth,
    parameter int ReadLatency = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  load_store_operation_t req_op_i,
    input  ddr_address_t          req_addr_i,
    input  logic                  wdata_valid_i,
    input  ddr_data_t             wdata_i,
    output logic                  wdata_ready_o,
    output logic                  rdata_valid_o,
    output ddr_data_t             rdata_o,
    output logic                  rdata_last_o,
    input  logic                  rdata_ready_i,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int AW   = $clog2(MemDepth);
    localparam int LatW = $clog2(ReadLatency + 2);

    typedef logic [AW-1:0] mem_index_t;

    localparam DI_t             LastK   = DI_t'(D - 1);
    localparam logic [LatW-1:0] LatLast = LatW'(ReadLatency - 1);

    responder_state_t state_r, state_next_s;
    mem_index_t       base_r, base_next_s;
    DI_t              k_r, k_next_s;
    logic [LatW-1:0]  lat_r, lat_next_s;

    logic       mem_we_s, mem_re_s;
    mem_index_t mem_addr_s;
    logic       done_next_s, err_next_s;

    logic req_ready_r, wdata_ready_r, rdata_valid_r, rdata_last_r, done_r, err_r;

    // Addresses wider than the memory simply alias modulo MemDepth.
    if (AW < DdrAddressWidth) begin : g_addr_alias
        logic unused_addr_s;
        assign unused_addr_s = ^req_addr_i[DdrAddressWidth-1:AW];
    end

    // Next-state, index/latency counters and memory port control.
    always_comb begin
        state_next_s = state_r;
        base_next_s  = base_r;
        k_next_s     = k_r;
        lat_next_s   = lat_r;
        mem_we_s     = 1'b0;
        mem_re_s     = 1'b0;
        mem_addr_s   = base_r + mem_index_t'(k_r);
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    base_next_s = req_addr_i[AW-1:0];
                    k_next_s    = '0;
                    lat_next_s  = '0;
                    case (req_op_i)
                        LDV: begin
                            mem_re_s     = 1'b1;
                            mem_addr_s   = req_addr_i[AW-1:0];
                            state_next_s = (ReadLatency == 0) ? ST_RD_STREAM : ST_RD_WAIT;
                        end
                        SV: begin
                            state_next_s = ST_WR_STREAM;
                        end
                        default: begin
                            err_next_s   = 1'b1;
                            state_next_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (lat_r == LatLast) begin
                    state_next_s = ST_RD_STREAM;
                end else begin
                    lat_next_s = lat_r + LatW'(1);
                end
            end
            ST_RD_STREAM: begin
                if (rdata_ready_i) begin
                    if (k_r == LastK) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        k_next_s   = k_r + DI_t'(1);
                        mem_re_s   = 1'b1;
                        mem_addr_s = base_r + mem_index_t'(k_r + DI_t'(1));
                    end
                end else begin
                    state_next_s = ST_RD_STREAM;
                end
            end
            ST_WR_STREAM: begin
                if (wdata_valid_i) begin
                    mem_we_s = 1'b1;
                    if (k_r == LastK) begin
                        state_next_s = ST_IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        k_next_s = k_r + DI_t'(1);
                    end
                end else begin
                    state_next_s = ST_WR_STREAM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            base_r        <= '0;
            k_r           <= '0;
            lat_r         <= '0;
            req_ready_r   <= 1'b1;
            wdata_ready_r <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            base_r        <= base_next_s;
            k_r           <= k_next_s;
            lat_r         <= lat_next_s;
            req_ready_r   <= (state_next_s == ST_IDLE);
            wdata_ready_r <= (state_next_s == ST_WR_STREAM);
            rdata_valid_r <= (state_next_s == ST_RD_STREAM);
            rdata_last_r  <= (state_next_s == ST_RD_STREAM) && (k_next_s == LastK);
            done_r        <= done_next_s;
            err_r         <= err_next_s;
        end
    end

    // A write coinciding with reset is dropped so an abandoned store stops cleanly.
    ddr_mem_array #(
        .Depth (MemDepth),
        .Width (DdrDataWidth)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we_s & ~rst_i),
        .re_i    (mem_re_s),
        .addr_i  (mem_addr_s),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );

    assign req_ready_o   = req_ready_r;
    assign wdata_ready_o = wdata_ready_r;
    assign rdata_valid_o = rdata_valid_r;
    assign rdata_last_o  = rdata_last_r;
    assign done_o        = done_r;
    assign err_o         = err_r;

endmodule
